// File: rtl/cpu_mult_iter_if.sv
// cpu_mult_iter_if: operand/result valid-ready bundle between the A-stage latch and the writeback mux
interface cpu_mult_iter_if #(parameter int DATA_W = 32);
   logic              in_valid, in_ready, out_valid, out_ready;
   logic [1:0]        op;
   logic [DATA_W-1:0] src1, src2, result;
   modport master(output in_valid, op, src1, src2, out_ready, input in_ready, out_valid, result);
   modport slave(input in_valid, op, src1, src2, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/cpu_mult_iter.sv
// cpu_mult_iter: iterative DATA_W x SLICE_W slice multiplier; CPU_MULT_HIGH_EN enables signed/unsigned high-word ops
module cpu_mult_iter #(
   parameter int DATA_W  = 32,
   parameter int SLICE_W = 16
) (
   input logic            clk,
   input logic            reset,
   cpu_mult_iter_if.slave bus
);
   localparam int N  = DATA_W / SLICE_W;
   localparam int CW = N > 1 ? $clog2(N) : 1;
`ifdef CPU_MULT_HIGH_EN
   localparam int AW = 2 * DATA_W;
`else
   localparam int AW = DATA_W;
`endif
   localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, FIX = 2'd2, DONE = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [DATA_W-1:0]         mag1_q, mag1_d, mag2_q, mag2_d, result_q, result_d;
   logic [AW-1:0]             acc_q, acc_d, acc_fix;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [DATA_W+SLICE_W-1:0] pp;
   logic                      accept, last;
`ifdef CPU_MULT_HIGH_EN
   logic                      neg_q, neg_d, s1, s2;
   logic [1:0]                op_q, op_d;
`endif

   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.result    = result_q;

   // next-state: operand capture, one slice per ACCUM cycle, sign fix and word select in FIX
   always_comb begin
      accept  = state_q == IDLE && bus.in_valid;
      last    = cnt_q == CW'(N - 1);
      pp      = {{SLICE_W{1'b0}}, mag1_q} * {{DATA_W{1'b0}}, mag2_q[SLICE_W-1:0]};
      state_d = accept ? ACCUM :
                state_q == ACCUM && last ? FIX :
                state_q == FIX ? DONE :
                state_q == DONE && bus.out_ready ? IDLE : state_q;
`ifdef CPU_MULT_HIGH_EN
      s1       = bus.op[1] && bus.src1[DATA_W-1];
      s2       = bus.op == 2'd3 && bus.src2[DATA_W-1];
      mag1_d   = accept ? (s1 ? -bus.src1 : bus.src1) : mag1_q;
      mag2_d   = accept ? (s2 ? -bus.src2 : bus.src2) : state_q == ACCUM ? mag2_q >> SLICE_W : mag2_q;
      neg_d    = accept ? s1 ^ s2 : neg_q;
      op_d     = accept ? bus.op : op_q;
      acc_fix  = neg_q ? -acc_q : acc_q;
      result_d = state_q == FIX ? (op_q == 2'd0 ? acc_fix[DATA_W-1:0] : acc_fix[AW-1:DATA_W]) : result_q;
`else
      mag1_d   = accept ? bus.src1 : mag1_q;
      mag2_d   = accept ? bus.src2 : state_q == ACCUM ? mag2_q >> SLICE_W : mag2_q;
      acc_fix  = acc_q;
      result_d = state_q == FIX ? acc_fix : result_q;
`endif
      acc_d = accept ? '0 :
              state_q == ACCUM ? acc_q + (AW'(pp) << (cnt_q * SLICE_W)) :
              state_q == FIX ? acc_fix : acc_q;
      cnt_d = accept ? '0 : state_q == ACCUM ? cnt_q + 1'b1 : cnt_q;
   end

   // state registers; reset discards any in-flight operation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         mag1_q   <= '0;
         mag2_q   <= '0;
         result_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
`ifdef CPU_MULT_HIGH_EN
         neg_q    <= 1'b0;
         op_q     <= 2'd0;
`endif
      end else begin
         state_q  <= state_d;
         mag1_q   <= mag1_d;
         mag2_q   <= mag2_d;
         result_q <= result_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
`ifdef CPU_MULT_HIGH_EN
         neg_q    <= neg_d;
         op_q     <= op_d;
`endif
      end
   end
endmodule

// File: tb/tb_cpu_mult_iter.sv
// tb_cpu_mult_iter: scoreboard bench for cpu_mult_iter (32/16), expectations follow CPU_MULT_HIGH_EN
module tb_cpu_mult_iter;
   logic        clk = 1'b0, reset = 1'b1, prev_v = 1'b0;
   int          cyc = 0, n_cmp = 0, n_err = 0;
   logic [31:0] exp_q[$];
   int          lat_q[$];

   cpu_mult_iter_if #(.DATA_W(32)) bus();
   cpu_mult_iter #(.DATA_W(32), .SLICE_W(16)) dut(.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sel(input logic [31:0] hi, input logic [31:0] lo);
`ifdef CPU_MULT_HIGH_EN
      return hi;
`else
      return lo;
`endif
   endfunction

   // monitor: latency on each rising out_valid, result on each handshake
   always @(negedge clk) begin
      if (!reset && bus.out_valid && !prev_v) begin
         if (lat_q.size() == 0) chk("stray_valid", 32'(lat_q.size()), 32'd1);
         else chk("latency", 32'(cyc - lat_q.pop_front()), 32'd3);
      end
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) chk("stray_result", 32'(exp_q.size()), 32'd1);
         else chk("result", bus.result, exp_q.pop_front());
      end
      prev_v <= bus.out_valid;
   end

   task automatic wait_ready();
      int k = 0;
      while (!bus.in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input bit push);
      wait_ready();
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.src1     = a;
      bus.src2     = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.op       = 2'd3;
      bus.src1     = 32'h5555AAAA;
      bus.src2     = 32'hDEADBEEF;
      if (push) begin
         exp_q.push_back(sel(hi, lo));
         lat_q.push_back(cyc);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo);
      issue(op, a, b, hi, lo, 1'b1);
      @(negedge clk);
      wait_ready();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1);
   end

   initial begin
      int k;
      bus.in_valid  = 1'b0;
      bus.op        = 2'd0;
      bus.src1      = '0;
      bus.src2      = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      issue(2'd0, 32'd7, 32'd6, 32'h2A, 32'h2A, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      wait_ready();
      run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
      run_op(2'd3, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
      run_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      run_op(2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
      run_op(2'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
      run_op(2'd2, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op(2'd3, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000);
      run_op(2'd0, 32'h00010003, 32'h00020005, 32'h000B000F, 32'h000B000F);
      bus.out_ready = 1'b0;
      issue(2'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b1);
      k = 0;
      while (!bus.out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.op       = 2'd0;
         bus.src1     = 32'd1;
         bus.src2     = 32'd1;
         @(negedge clk);
         chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_result", bus.result, sel(32'h3FFFFFFF, 32'h00000001));
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
      run_op(2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_result", bus.result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) begin
         @(negedge clk);
         chk("no_stale_valid", 32'(bus.out_valid), 32'd0);
      end
      run_op(2'd0, 32'd3, 32'd5, 32'h0000000F, 32'h0000000F);
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
